// File: rtl/axc_error_sweeper_if.sv
// Connection bundle between the error sweeper and the exact/approximate circuit pair.
// The slave side belongs to the sweeper; the master side to whatever hosts the circuit pair.
interface axc_error_sweeper_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2
);
    logic                    start;
    logic                    abort;
    logic [N_IN-1:0]         vec;
    logic [N_OUT-1:0]        exact_in;
    logic [N_OUT-1:0]        approx_in;
    logic                    busy;
    logic                    done;
    logic [N_OUT-1:0]        max_err;
    logic [N_OUT+N_IN-1:0]   err_sum;
    logic [N_IN:0]           viol_cnt;
    logic                    pass;

    modport master (
        output start, abort, exact_in, approx_in,
        input  vec, busy, done, max_err, err_sum, viol_cnt, pass
    );

    modport slave (
        input  start, abort, exact_in, approx_in,
        output vec, busy, done, max_err, err_sum, viol_cnt, pass
    );
endinterface

// File: rtl/axc_error_sweeper.sv
// Exhaustively sweeps all 2^N_IN input vectors through an exact/approximate circuit pair
// and accumulates max error, error sum and threshold-violation count.
module axc_error_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 2,
    parameter int ET    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axc_error_sweeper_if.slave   bus
);
    localparam int SUM_W = N_OUT + N_IN;
    localparam int CNT_W = N_IN + 1;

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [N_IN-1:0]      vec_q, vec_d;
    logic [N_OUT-1:0]     diff_p1_q, diff_p1_d;
    logic                 vld_p1_q, vld_p1_d;
    logic [N_OUT-1:0]     max_err_q, max_err_d;
    logic [SUM_W-1:0]     err_sum_q, err_sum_d;
    logic [CNT_W-1:0]     viol_cnt_q, viol_cnt_d;
    logic                 pass_q, pass_d;

    function automatic logic [N_OUT-1:0] abs_diff(input logic [N_OUT-1:0] a,
                                                 input logic [N_OUT-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic over_threshold(input logic [N_OUT-1:0] d);
        return int'(d) > ET;
    endfunction

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        diff_p1_d  = diff_p1_q;
        vld_p1_d   = vld_p1_q;
        max_err_d  = max_err_q;
        err_sum_d  = err_sum_q;
        viol_cnt_d = viol_cnt_q;
        pass_d     = pass_q;

        // Stage p1 -> accumulators: fold in the diff registered on the previous edge
        if (vld_p1_q) begin
            if (diff_p1_q > max_err_q) max_err_d = diff_p1_q;
            err_sum_d = err_sum_q + SUM_W'(diff_p1_q);
            if (over_threshold(diff_p1_q)) viol_cnt_d = viol_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_SWEEP;
                    vec_d      = '0;
                    vld_p1_d   = 1'b0;
                    max_err_d  = '0;
                    err_sum_d  = '0;
                    viol_cnt_d = '0;
                    pass_d     = 1'b0;
                end
            end
            S_SWEEP: begin
                // Stage p0 -> p1: capture the circuit responses to the current vec
                diff_p1_d = abs_diff(bus.exact_in, bus.approx_in);
                vld_p1_d  = 1'b1;
                if (vec_q == {N_IN{1'b1}}) state_d = S_DRAIN;
                else                       vec_d   = vec_q + N_IN'(1);
            end
            S_DRAIN: begin
                vld_p1_d = 1'b0;
                state_d  = S_DONE;
                // Pass is taken from the final count so it is valid alongside done
                pass_d   = (viol_cnt_d == '0);
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (bus.abort && (state_q == S_SWEEP || state_q == S_DRAIN)) begin
            state_d    = S_IDLE;
            vec_d      = '0;
            vld_p1_d   = 1'b0;
            max_err_d  = '0;
            err_sum_d  = '0;
            viol_cnt_d = '0;
            pass_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            diff_p1_q  <= '0;
            vld_p1_q   <= 1'b0;
            max_err_q  <= '0;
            err_sum_q  <= '0;
            viol_cnt_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            diff_p1_q  <= diff_p1_d;
            vld_p1_q   <= vld_p1_d;
            max_err_q  <= max_err_d;
            err_sum_q  <= err_sum_d;
            viol_cnt_q <= viol_cnt_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.vec      = vec_q;
    assign bus.busy     = (state_q == S_SWEEP) || (state_q == S_DRAIN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.max_err  = max_err_q;
    assign bus.err_sum  = err_sum_q;
    assign bus.viol_cnt = viol_cnt_q;
    assign bus.pass     = pass_q;
endmodule

// File: doc/axc_error_sweeper.md
AXC_ERROR_SWEEPER -- requirements
Module: axc_error_sweeper

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of primary inputs of the circuit pair under test.
REQ-002 The block SHALL have parameter N_OUT, default 2, meaning the output width of the exact and approximate circuits, read as an unsigned value.
REQ-003 The block SHALL have parameter ET, default 2, meaning the error threshold; a vector violates when |exact-approx| > ET.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 Port start, input, 1 bit: request a sweep; it SHALL be sampled only in IDLE.
REQ-007 Port abort, input, 1 bit: synchronous cancel of a running sweep.
REQ-008 Port vec, output, N_IN bits: registered stimulus driven to both the exact and the approximate circuit.
REQ-009 Port exact_in, input, N_OUT bits: combinational response of the exact circuit to vec.
REQ-010 Port approx_in, input, N_OUT bits: combinational response of the approximate circuit to vec.
REQ-011 Port busy, output, 1 bit: high in SWEEP and DRAIN.
REQ-012 Port done, output, 1 bit: one-cycle pulse when results are valid.
REQ-013 Port max_err, output, N_OUT bits: maximum |exact-approx| over the sweep.
REQ-014 Port err_sum, output, N_OUT+N_IN bits: sum of |exact-approx| over all vectors.
REQ-015 Port viol_cnt, output, N_IN+1 bits: count of vectors with error greater than ET.
REQ-016 Port pass, output, 1 bit: 1 when viol_cnt==0 at sweep completion.

Function
REQ-017 The FSM SHALL have the states IDLE, SWEEP, DRAIN and DONE; let N=2^N_IN.
REQ-018 IDLE with start=1 at an edge SHALL move to SWEEP, set vec=0, clear the diff-valid flag, and clear max_err, err_sum, viol_cnt and pass.
REQ-019 SWEEP, at each edge: register diff=|exact_in-approx_in| for the current vec, computed unsigned with no wrap; set diff-valid; increment vec.
REQ-020 SWEEP with vec==N-1 at an edge SHALL keep vec at N-1 and move to DRAIN; vec SHALL never wrap during a sweep.
REQ-021 At any edge with diff-valid=1: max_err<=max(max_err,diff); err_sum<=err_sum+diff; viol_cnt increments if diff>ET.
REQ-022 DRAIN SHALL accumulate the final diff, clear diff-valid, and move to DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, set pass=(viol_cnt==0) as a registered value, and return to IDLE.
REQ-024 done SHALL go high in the cycle following edge N+1, counted from the edge that sampled start.
REQ-025 Results SHALL hold stable in IDLE until the next accepted start.
REQ-026 start in SWEEP, DRAIN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-027 abort=1 in SWEEP or DRAIN SHALL go to IDLE at that edge with no done pulse, vec=0, results cleared and pass=0; abort SHALL take priority over every other transition.
REQ-028 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-029 rst_n=0 SHALL immediately force: state=IDLE, vec=0, busy=0, done=0, max_err=0, err_sum=0, viol_cnt=0, pass=0, diff-valid=0.
REQ-030 Reset mid-sweep SHALL discard all partial results; the first start after deassertion SHALL run a full N-vector sweep.

Verification
REQ-031 Bench: approx_in=exact_in for all vec -> done 17 cycles after start, max_err=0, err_sum=0, viol_cnt=0, pass=1.
REQ-032 Bench: exact_in=3, approx_in=0 constant -> max_err=3, err_sum=48, viol_cnt=16, pass=0.
REQ-033 Bench: approx_in=exact_in except at vec=5, where the difference is 3 -> max_err=3, err_sum=3, viol_cnt=1, pass=0; a difference of exactly 2 at vec=5 -> viol_cnt=0, pass=1.
REQ-034 Bench: start pulsed at cycles 3 and 8 after the first start -> only one done pulse, still at cycle 17.
REQ-035 Bench: abort at vec=7 -> busy=0 next cycle, no done, results 0; a following start yields a complete, correct sweep.
REQ-036 Bench: rst_n low at vec=9 -> all outputs 0 immediately; a new start gives results identical to an uninterrupted run.
